xy_route_stage: RTL and testbench

//  Parametrised XY route-compute stage for one mesh router node. Accepts flits on NUM_CH input

---
 rtl/xy_route_stage_if.sv | 32 +++
 rtl/xy_route_stage.sv | 117 +++++++++++
 tb/tb_xy_route_stage.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/xy_route_stage_if.sv
// Flit bus for the XY route-compute stage: link-side inputs plus the buffered,
// routed heads presented to the switch allocator.
interface xy_route_stage_if #(
  parameter int COORD_W = 3,
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 8
);
  localparam int AW = 2 * COORD_W;

  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH*AW-1:0]     in_addr;
  logic [NUM_CH*DATA_W-1:0] in_data;

  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH*AW-1:0]     out_addr;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH*5-1:0]      out_dir;
  logic [NUM_CH-1:0]        out_err;
  logic [7:0]               err_cnt;

  modport master (
    output in_valid, in_addr, in_data, out_ready,
    input  in_ready, out_valid, out_addr, out_data, out_dir, out_err, err_cnt
  );

  modport slave (
    input  in_valid, in_addr, in_data, out_ready,
    output in_ready, out_valid, out_addr, out_data, out_dir, out_err, err_cnt
  );
endinterface

// File: rtl/xy_route_stage.sv
// XY route-compute stage: per-channel 2-entry FIFOs that store each flit with its
// one-hot output direction (E,W,N,S,LOCAL) and an out-of-mesh error flag.
module xy_route_stage #(
  parameter int COORD_W   = 3,
  parameter int NODE_ROW  = 4,
  parameter int NODE_COL  = 4,
  parameter int MESH_ROWS = 8,
  parameter int MESH_COLS = 8,
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 8
) (
  input logic         clk,
  input logic         rst_n,
  xy_route_stage_if.slave bus
);
  localparam int AW = 2 * COORD_W;
  localparam logic [COORD_W:0]   ROW_LIM = MESH_ROWS[COORD_W:0];
  localparam logic [COORD_W:0]   COL_LIM = MESH_COLS[COORD_W:0];
  localparam logic [COORD_W-1:0] MY_ROW  = NODE_ROW[COORD_W-1:0];
  localparam logic [COORD_W-1:0] MY_COL  = NODE_COL[COORD_W-1:0];

  // Returns {err, dir}; column is resolved before row (dimension-ordered XY).
  function automatic logic [5:0] compute_route(input logic [AW-1:0] a);
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic [5:0]         r;
    row = a[AW-1:COORD_W];
    col = a[COORD_W-1:0];
    if (({1'b0, row} >= ROW_LIM) || ({1'b0, col} >= COL_LIM)) r = 6'b100000;
    else if (col > MY_COL) r = 6'b000001;
    else if (col < MY_COL) r = 6'b000010;
    else if (row > MY_ROW) r = 6'b000100;
    else if (row < MY_ROW) r = 6'b001000;
    else                   r = 6'b010000;
    return r;
  endfunction

  logic [NUM_CH-1:0] push_err;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [AW-1:0]     addr_mem [2];
    logic [DATA_W-1:0] data_mem [2];
    logic [5:0]        route_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              ready_q;
    logic [1:0]        count;
    logic [1:0]        count_nxt;
    logic              push;
    logic              pop;
    logic              head_valid;
    logic [5:0]        route_in;

    assign route_in   = compute_route(bus.in_addr[i*AW +: AW]);
    assign head_valid = (count != 2'd0);
    assign push       = bus.in_valid[i] & ready_q;
    assign pop        = head_valid & bus.out_ready[i];
    assign push_err[i] = push & route_in[5];

    always_comb begin
      count_nxt = count;
      if (push && !pop)      count_nxt = count + 2'd1;
      else if (pop && !push) count_nxt = count - 2'd1;
    end

    // in_ready is registered from the next occupancy, so out_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int e = 0; e < 2; e++) begin
          addr_mem[e]  <= '0;
          data_mem[e]  <= '0;
          route_mem[e] <= '0;
        end
        wr_ptr  <= 1'b0;
        rd_ptr  <= 1'b0;
        count   <= 2'd0;
        ready_q <= 1'b1;
      end else begin
        if (push) begin
          addr_mem[wr_ptr]  <= bus.in_addr[i*AW +: AW];
          data_mem[wr_ptr]  <= bus.in_data[i*DATA_W +: DATA_W];
          route_mem[wr_ptr] <= route_in;
          wr_ptr            <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        count   <= count_nxt;
        ready_q <= (count_nxt < 2'd2);
      end
    end

    assign bus.in_ready[i]              = ready_q;
    assign bus.out_valid[i]             = head_valid;
    assign bus.out_addr[i*AW +: AW]     = head_valid ? addr_mem[rd_ptr] : '0;
    assign bus.out_data[i*DATA_W +: DATA_W] = head_valid ? data_mem[rd_ptr] : '0;
    assign bus.out_dir[i*5 +: 5]        = head_valid ? route_mem[rd_ptr][4:0] : '0;
    assign bus.out_err[i]               = head_valid & route_mem[rd_ptr][5];
  end

  logic [15:0] err_inc;
  logic [16:0] err_sum;
  logic [7:0]  err_cnt_q;

  always_comb begin
    err_inc = '0;
    for (int i = 0; i < NUM_CH; i++) err_inc = err_inc + 16'(push_err[i]);
  end

  assign err_sum = {9'b0, err_cnt_q} + {1'b0, err_inc};

  // Saturating so a flood of misrouted traffic cannot wrap the counter back to a small value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'd0;
    else        err_cnt_q <= (err_sum > 17'd255) ? 8'hFF : err_sum[7:0];
  end

  assign bus.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_xy_route_stage.sv
// Bench for xy_route_stage: a default 8x8 instance and a 6-column instance share
// stimulus; per-channel flit queues model expected heads, routes and err_cnt.
module tb_xy_route_stage;
  typedef logic [13:0] flit_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [3:0]  out_ready;
  logic [23:0] in_addr;
  logic [31:0] in_data;

  flit_t mq [8][$];
  int    err_m [2];
  int    mesh_cols_m [2];
  int    popped [8];
  int    checks;
  int    fails;

  xy_route_stage_if bus_m ();
  xy_route_stage_if bus_e ();

  assign bus_m.in_valid  = in_valid;
  assign bus_m.out_ready = out_ready;
  assign bus_m.in_addr   = in_addr;
  assign bus_m.in_data   = in_data;
  assign bus_e.in_valid  = in_valid;
  assign bus_e.out_ready = out_ready;
  assign bus_e.in_addr   = in_addr;
  assign bus_e.in_data   = in_data;

  xy_route_stage dut_main (.clk(clk), .rst_n(rst_n), .bus(bus_m));
  xy_route_stage #(.MESH_COLS(6)) dut_err (.clk(clk), .rst_n(rst_n), .bus(bus_e));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Node sits at (4,4); mesh is 8 rows by `cols` columns. Result is {err, one-hot dir}.
  function automatic logic [5:0] model_route(input logic [5:0] a, input int cols);
    int row;
    int col;
    int sel;
    row = int'(a[5:3]);
    col = int'(a[2:0]);
    if (row >= 8 || col >= cols) return 6'b100000;
    if (col != 4)      sel = (col > 4) ? 0 : 1;
    else if (row != 4) sel = (row > 4) ? 2 : 3;
    else               sel = 4;
    return {1'b0, 5'(1 << sel)};
  endfunction

  task automatic check_inst(input int k, input logic [3:0] ov, input logic [3:0] ir,
                            input logic [23:0] oa, input logic [31:0] od, input logic [19:0] odir,
                            input logic [3:0] oerr, input logic [7:0] ocnt);
    int    idx;
    flit_t h;
    logic [5:0] er;
    for (int i = 0; i < 4; i++) begin
      idx = k * 4 + i;
      check_output($sformatf("d%0d ch%0d out_valid", k, i), 32'(ov[i]), 32'(mq[idx].size() > 0));
      check_output($sformatf("d%0d ch%0d in_ready", k, i), 32'(ir[i]), 32'(mq[idx].size() < 2));
      if (mq[idx].size() > 0) begin
        h  = mq[idx][0];
        er = model_route(h[13:8], mesh_cols_m[k]);
        check_output($sformatf("d%0d ch%0d out_addr", k, i), 32'(oa[i*6 +: 6]), 32'(h[13:8]));
        check_output($sformatf("d%0d ch%0d out_data", k, i), 32'(od[i*8 +: 8]), 32'(h[7:0]));
        check_output($sformatf("d%0d ch%0d out_dir", k, i), 32'(odir[i*5 +: 5]), 32'(er[4:0]));
        check_output($sformatf("d%0d ch%0d out_err", k, i), 32'(oerr[i]), 32'(er[5]));
      end else begin
        check_output($sformatf("d%0d ch%0d idle addr", k, i), 32'(oa[i*6 +: 6]), 32'd0);
        check_output($sformatf("d%0d ch%0d idle data", k, i), 32'(od[i*8 +: 8]), 32'd0);
        check_output($sformatf("d%0d ch%0d idle dir", k, i), 32'(odir[i*5 +: 5]), 32'd0);
        check_output($sformatf("d%0d ch%0d idle err", k, i), 32'(oerr[i]), 32'd0);
      end
    end
    check_output($sformatf("d%0d err_cnt", k), 32'(ocnt), 32'(err_m[k]));
  endtask

  task automatic check_state();
    check_inst(0, bus_m.out_valid, bus_m.in_ready, bus_m.out_addr, bus_m.out_data,
               bus_m.out_dir, bus_m.out_err, bus_m.err_cnt);
    check_inst(1, bus_e.out_valid, bus_e.in_ready, bus_e.out_addr, bus_e.out_data,
               bus_e.out_dir, bus_e.out_err, bus_e.err_cnt);
  endtask

  task automatic clear_model();
    for (int idx = 0; idx < 8; idx++) mq[idx].delete();
    err_m[0] = 0;
    err_m[1] = 0;
  endtask

  // Called at a falling edge: check current state, drive one cycle, advance the model.
  task automatic apply_stimulus(input logic [3:0] v, input logic [3:0] ordy, input logic [23:0] addr,
                                input logic [31:0] data, output logic [3:0] pushed);
    int    idx;
    int    sz;
    int    nerr;
    logic  ov;
    logic [5:0] er;
    check_state();
    in_valid  = v;
    out_ready = ordy;
    in_addr   = addr;
    in_data   = data;
    pushed    = '0;
    for (int k = 0; k < 2; k++) begin
      nerr = 0;
      for (int i = 0; i < 4; i++) begin
        idx = k * 4 + i;
        sz  = mq[idx].size();
        ov  = (k == 0) ? bus_m.out_valid[i] : bus_e.out_valid[i];
        if (ov && ordy[i]) popped[idx]++;
        if (sz > 0 && ordy[i]) void'(mq[idx].pop_front());
        if (v[i] && sz < 2) begin
          mq[idx].push_back({addr[i*6 +: 6], data[i*8 +: 8]});
          er = model_route(addr[i*6 +: 6], mesh_cols_m[k]);
          if (er[5]) nerr++;
          if (k == 0) pushed[i] = 1'b1;
        end
      end
      err_m[k] = (err_m[k] + nerr > 255) ? 255 : err_m[k] + nerr;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] p;
    logic [5:0] t2 [5];
    logic [7:0] vals [3];
    int kk;

    checks = 0;
    fails  = 0;
    mesh_cols_m[0] = 8;
    mesh_cols_m[1] = 6;
    for (int idx = 0; idx < 8; idx++) popped[idx] = 0;
    clear_model();
    rst_n = 1'b0;
    in_valid = '0;
    out_ready = '0;
    in_addr = '0;
    in_data = '0;

    repeat (2) @(negedge clk);
    check_state();
    rst_n = 1'b1;
    apply_stimulus(4'h0, 4'h0, 24'h0, 32'h0, p);

    // Directed routes on ch0: {4,6} E, {4,1} W, {6,4} N, {2,4} S, {4,4} LOCAL.
    t2[0] = 6'o46; t2[1] = 6'o41; t2[2] = 6'o64; t2[3] = 6'o24; t2[4] = 6'o44;
    for (int j = 0; j < 5; j++) begin
      apply_stimulus(4'b0001, 4'hF, {18'b0, t2[j]}, $urandom, p);
      apply_stimulus(4'b0000, 4'hF, 24'h0, 32'h0, p);
    end

    // Backpressure on ch1: A,B fill the FIFO, C waits until the downstream drains.
    vals[0] = 8'hA1; vals[1] = 8'hB2; vals[2] = 8'hC3;
    kk = 0;
    for (int c = 0; c < 10; c++) begin
      apply_stimulus((kk < 3) ? 4'b0010 : 4'b0000, (c < 4) ? 4'b0000 : 4'b0010,
                     {12'b0, 6'o33, 6'b0}, {16'b0, vals[(kk < 3) ? kk : 2], 8'b0}, p);
      if (p[1]) kk++;
    end

    // Out-of-range column on the 6-column instance, then flood it to saturation.
    apply_stimulus(4'b1100, 4'hF, {6'o47, 6'o47, 12'b0}, $urandom, p);
    apply_stimulus(4'b0000, 4'hF, 24'h0, 32'h0, p);
    for (int c = 0; c < 80; c++) apply_stimulus(4'hF, 4'hF, {4{6'o47}}, $urandom, p);
    repeat (2) apply_stimulus(4'h0, 4'hF, 24'h0, 32'h0, p);

    // Sustained full-rate traffic on all channels.
    for (int idx = 0; idx < 8; idx++) popped[idx] = 0;
    for (int c = 0; c < 20; c++) apply_stimulus(4'hF, 4'hF, 24'($urandom), $urandom, p);
    repeat (2) apply_stimulus(4'h0, 4'hF, 24'h0, 32'h0, p);
    for (int idx = 0; idx < 8; idx++)
      check_output($sformatf("stream count idx%0d", idx), 32'(popped[idx]), 32'd20);

    for (int c = 0; c < 400; c++)
      apply_stimulus(4'($urandom), 4'($urandom), 24'($urandom), $urandom, p);
    repeat (3) apply_stimulus(4'h0, 4'hF, 24'h0, 32'h0, p);

    // Fill ch0, then reset mid-cycle: the FIFO must empty without waiting for a clock edge.
    apply_stimulus(4'b0001, 4'h0, 24'($urandom), $urandom, p);
    apply_stimulus(4'b0001, 4'h0, 24'($urandom), $urandom, p);
    check_state();
    #2;
    rst_n = 1'b0;
    in_valid = '0;
    #1;
    check_output("async out_valid0 main", 32'(bus_m.out_valid[0]), 32'd0);
    check_output("async in_ready0 main", 32'(bus_m.in_ready[0]), 32'd1);
    check_output("async out_valid0 err", 32'(bus_e.out_valid[0]), 32'd0);
    check_output("async in_ready0 err", 32'(bus_e.in_ready[0]), 32'd1);
    clear_model();
    @(negedge clk);
    check_state();
    rst_n = 1'b1;
    repeat (3) apply_stimulus(4'h0, 4'hF, 24'h0, 32'h0, p);
    check_state();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
